tl45_adder_arbiter: RTL and testbench

- Shares one internal 32-bit Kogge-Stone adder (explicit carry-in) among NREQ requesters, e.g. ALU, address generation and branch target.
- Round-robin arbitration; one operation in flight at a time.
- 32-bit operations take one adder pass; 64-bit operations take two passes, low word then high word, with the carry chained between them.
- Results return on a single valid/ready response channel tagged with the requester index.

---
 rtl/tl45_adder_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_tl45_adder_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tl45_adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit Kogge-Stone adder; 64-bit ops take two chained passes.
// Optional macro TL45_ADDARB_PRIO0_EN gives requester 0 fixed top priority over the round robin.
module tl45_adder_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*64-1:0]   i_req_a,
  input  logic [NREQ*64-1:0]   i_req_b,
  input  logic [NREQ-1:0]      i_req_sub,
  input  logic [NREQ-1:0]      i_req_wide,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [63:0]          o_rsp_sum,
  output logic                 o_rsp_cout,
  output logic                 o_rsp_ovf
);

`ifdef TL45_ADDARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [63:0]    r_a;
  logic [63:0]    r_b;
  logic           r_sub;
  logic           r_wide;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_lo_sum;
  logic           r_c31;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [63:0]    r_rsp_sum;
  logic           r_rsp_cout;
  logic           r_rsp_ovf;

  logic           w_found;
  logic [IDW-1:0] w_win;
  int unsigned    v_dist;
  int unsigned    v_best;
  logic [NREQ-1:0] w_req_ready;
  logic [63:0]    w_sel_a;
  logic [63:0]    w_sel_b;
  logic           w_sel_sub;
  logic           w_sel_wide;

  // Winner = valid requester at the smallest rotational distance past the pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    v_dist  = 0;
    v_best  = NREQ;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i_req_valid[i]) begin
        v_dist = (i + 2 * NREQ - 32'(r_ptr) - 1) % NREQ;
        if (PRIO0 && (i == 0)) v_dist = 0;
        if (v_dist < v_best) begin
          v_best  = v_dist;
          w_win   = IDW'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    if ((r_state == S_IDLE) && !i_reset && w_found) w_req_ready = NREQ'(1) << w_win;
  end

  assign o_req_ready = w_req_ready;

  // Operand select from the granted requester
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_sub  = 1'b0;
    w_sel_wide = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_req_ready[i]) begin
        w_sel_a    = i_req_a[64*i +: 64];
        w_sel_b    = i_req_b[64*i +: 64];
        w_sel_sub  = i_req_sub[i];
        w_sel_wide = i_req_wide[i];
      end
    end
  end

  logic        w_hi_pass;
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_cin;
  logic [31:0] w_g0, w_g1, w_g2, w_g3, w_g4, w_g5;
  logic [31:0] w_p0, w_p1, w_p2, w_p3, w_p4, w_p5;
  logic [31:0] w_carry;
  logic [31:0] w_sum;
  logic        w_cout;

  assign w_hi_pass = (r_state == S_HI);
  assign w_add_a   = w_hi_pass ? r_a[63:32] : r_a[31:0];
  assign w_add_b   = w_hi_pass ? r_b[63:32] : r_b[31:0];
  assign w_cin     = w_hi_pass ? r_c31 : r_sub;

  // Kogge-Stone prefix tree; low bits below each span pass through unchanged
  assign w_g0 = w_add_a & w_add_b;
  assign w_p0 = w_add_a ^ w_add_b;
  assign w_g1 = w_g0 | (w_p0 & (w_g0 << 1));
  assign w_p1 = w_p0 & ((w_p0 << 1) | 32'h0000_0001);
  assign w_g2 = w_g1 | (w_p1 & (w_g1 << 2));
  assign w_p2 = w_p1 & ((w_p1 << 2) | 32'h0000_0003);
  assign w_g3 = w_g2 | (w_p2 & (w_g2 << 4));
  assign w_p3 = w_p2 & ((w_p2 << 4) | 32'h0000_000F);
  assign w_g4 = w_g3 | (w_p3 & (w_g3 << 8));
  assign w_p4 = w_p3 & ((w_p3 << 8) | 32'h0000_00FF);
  assign w_g5 = w_g4 | (w_p4 & (w_g4 << 16));
  assign w_p5 = w_p4 & ((w_p4 << 16) | 32'h0000_FFFF);

  assign w_carry = {w_g5[30:0] | (w_p5[30:0] & {31{w_cin}}), w_cin};
  assign w_sum   = w_p0 ^ w_carry;
  assign w_cout  = w_g5[31] | (w_p5[31] & w_cin);

  // Control FSM with registered response outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_wide      <= 1'b0;
      r_id        <= '0;
      r_lo_sum    <= '0;
      r_c31       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req_ready) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_sub ? ~w_sel_b : w_sel_b;
            r_sub  <= w_sel_sub;
            r_wide <= w_sel_wide;
            r_id   <= w_win;
            if (!(PRIO0 && (w_win == '0))) r_ptr <= w_win;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          r_lo_sum <= w_sum;
          r_c31    <= w_cout;
          if (r_wide) begin
            r_state <= S_HI;
          end else begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_sum   <= {32'h0, w_sum};
            r_rsp_cout  <= w_cout;
            r_rsp_ovf   <= (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
          end
        end
        S_HI: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_sum   <= {w_sum, r_lo_sum};
          r_rsp_cout  <= w_cout;
          r_rsp_ovf   <= (r_a[63] == r_b[63]) && (w_sum[31] != r_a[63]);
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
  assign o_rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_tl45_adder_arbiter.sv
// Directed bench for tl45_adder_arbiter: reset/grant order, result vector table, hold and mid-op reset.
module tb_tl45_adder_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned IDW  = 2;

  logic                 clk;
  logic                 i_reset;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*64-1:0]   i_req_a;
  logic [NREQ*64-1:0]   i_req_b;
  logic [NREQ-1:0]      i_req_sub;
  logic [NREQ-1:0]      i_req_wide;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready;
  logic [IDW-1:0]       o_rsp_id;
  logic [63:0]          o_rsp_sum;
  logic                 o_rsp_cout;
  logic                 o_rsp_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  tl45_adder_arbiter #(.NREQ(NREQ)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_sub   (i_req_sub),
    .i_req_wide  (i_req_wide),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_sum   (o_rsp_sum),
    .o_rsp_cout  (o_rsp_cout),
    .o_rsp_ovf   (o_rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    bit          sub;
    bit          wide;
    int          hold;
    logic [63:0] sum;
    bit          cout;
    bit          ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // One request from a single requester, checked for grant, latency and result
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    i_req_valid = '0;
    i_req_valid[v.id] = 1'b1;
    i_req_a[64*v.id +: 64] = v.a;
    i_req_b[64*v.id +: 64] = v.b;
    i_req_sub[v.id]  = v.sub;
    i_req_wide[v.id] = v.wide;
    #1;
    check("grant", 64'(o_req_ready), 64'(3'b001 << v.id));
    @(negedge clk);
    i_req_valid = '0;
    i_req_a = {3{64'hA5A5_5A5A_F00F_0FF0}};
    i_req_b = {3{64'h1234_5678_9ABC_DEF0}};
    i_req_sub = ~i_req_sub;
    check("lat_lo", 64'(o_rsp_valid), 64'd0);
    if (v.wide) begin
      @(negedge clk);
      check("lat_hi", 64'(o_rsp_valid), 64'd0);
    end
    @(negedge clk);
    check("rsp_valid", 64'(o_rsp_valid), 64'd1);
    check("rsp_id", 64'(o_rsp_id), 64'(v.id));
    check("rsp_sum", o_rsp_sum, v.sum);
    check("rsp_cout", 64'(o_rsp_cout), 64'(v.cout));
    check("rsp_ovf", 64'(o_rsp_ovf), 64'(v.ovf));
    for (int h = 0; h < v.hold; h++) begin
      i_req_valid = '1;
      @(negedge clk);
      check("hold_valid", 64'(o_rsp_valid), 64'd1);
      check("hold_sum", o_rsp_sum, v.sum);
      check("hold_ready", 64'(o_req_ready), 64'd0);
    end
    i_req_valid = '0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop", 64'(o_rsp_valid), 64'd0);
    i_rsp_ready = 1'b0;
  endtask

  vec_t vecs[10];
  int   order[6];

  initial begin
    vecs[0] = '{1, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 64'h0000_0000_8000_0000, 1'b0, 1'b1};
    vecs[1] = '{2, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b1, 0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 0, 64'h0, 1'b1, 1'b0};
    vecs[3] = '{0, 64'h5, 64'h7, 1'b1, 1'b0, 4, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 64'h0, 1'b1, 1'b0};
    vecs[5] = '{1, 64'h8000_0000, 64'h1, 1'b1, 1'b0, 0, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{2, 64'h1_0000_0000, 64'h1, 1'b1, 1'b1, 0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{1, 64'hDEAD_BEEF_0000_0010, 64'h1234_5678_0000_0020, 1'b0, 1'b0, 0, 64'h30, 1'b0, 1'b0};
    vecs[8] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[9] = '{2, 64'h3, 64'h5, 1'b1, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
`ifdef TL45_ADDARB_PRIO0_EN
    order = '{0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif

    i_reset     = 1'b1;
    i_req_valid = '1;
    i_req_a     = '0;
    i_req_b     = '0;
    i_req_sub   = '0;
    i_req_wide  = '0;
    i_rsp_ready = 1'b0;

    // Reset held two cycles with every requester asserting valid
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_ready", 64'(o_req_ready), 64'd0);
      check("rst_valid", 64'(o_rsp_valid), 64'd0);
    end
    check("rst_sum", o_rsp_sum, 64'd0);
    check("rst_id", 64'(o_rsp_id), 64'd0);

    // Continuous contention, 32-bit adds, response accepted immediately
    for (int k = 0; k < 3; k++) begin
      i_req_a[64*k +: 64] = 64'(k + 1) << 8;
      i_req_b[64*k +: 64] = 64'h10;
    end
    i_rsp_ready = 1'b1;
    i_reset = 1'b0;
    #1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 3 == 0)
        check("rr_grant", 64'(o_req_ready), 64'(3'b001 << order[c / 3]));
      else
        check("rr_idle", 64'(o_req_ready), 64'd0);
      check("rr_valid", 64'(o_rsp_valid), 64'(c % 3 == 2));
      if (c % 3 == 2) begin
        check("rr_id", 64'(o_rsp_id), 64'(order[c / 3]));
        check("rr_sum", o_rsp_sum, (64'(order[c / 3] + 1) << 8) + 64'h10);
      end
    end
    @(negedge clk);
    i_req_valid = '0;
    i_rsp_ready = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while a 64-bit op sits in its high pass
    @(negedge clk);
    i_req_valid = 3'b010;
    i_req_a[127:64] = 64'h0000_0001_FFFF_FFFF;
    i_req_b[127:64] = 64'h1;
    i_req_sub[1]  = 1'b0;
    i_req_wide[1] = 1'b1;
    i_rsp_ready   = 1'b1;
    #1;
    check("mid_grant", 64'(o_req_ready), 64'd2);
    @(negedge clk);
    i_req_valid = '0;
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("mid_novalid", 64'(o_rsp_valid), 64'd0);
      @(negedge clk);
    end
    check("mid_sum", o_rsp_sum, 64'd0);
    i_rsp_ready = 1'b0;
    run_vec(vecs[1]);
    run_vec(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
